// File: rtl/instr_loader.sv
// Instruction loader: receives a 16-bit big-endian word count N followed by
// N*4 bytes over a valid/ready byte stream. It packs each group of four bytes
// into a 32-bit word and writes that word into instruction memory at
// consecutive word-aligned byte addresses. The downstream core is held
// (cpu_hold=1) until a complete image has been written.
//
// Handshake: a byte transfers on a rising edge where rx_valid=1 and
// rx_ready=1. The producer keeps rx_data stable while rx_valid=1 and
// rx_ready=0. rx_ready depends only on state, never on rx_valid.
module instr_loader #(
  parameter int ADDR_W    = 10,
  parameter bit FIRST_MSB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Memory depth in words. The width matches a zero-extended 16-bit N.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state;
  logic [15:0]       n;
  // One extra bit, so the index can reach DEPTH when the image fills memory.
  logic [ADDR_W:0]   word_idx;
  logic [1:0]        byte_cnt;
  logic [31:0]       word_q;

  logic              rx_fire;
  logic [31:0]       word_next;
  logic [15:0]       n_next;
  logic [ADDR_W:0]   word_idx_inc;

  assign rx_fire      = rx_valid & rx_ready;
  assign n_next       = {n[15:8], rx_data};
  assign word_idx_inc = word_idx + (ADDR_W+1)'(1);
  // FIRST_MSB=1 shifts left, so the first byte ends up in [31:24].
  // FIRST_MSB=0 shifts right, so the first byte ends up in [7:0].
  assign word_next    = FIRST_MSB ? {word_q[23:0], rx_data}
                                  : {rx_data, word_q[31:8]};

  // Moore outputs, decoded from the state register.
  assign rx_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
  assign mem_we    = (state == S_WRITE);
  assign busy      = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_WRITE);
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign cpu_hold  = (state != S_DONE);
  assign dbg_state = state;

  // Load FSM with its datapath registers. mem_addr and mem_wd are loaded
  // when a word completes, so they are already valid in the WRITE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      n        <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      word_q   <= '0;
      mem_addr <= '0;
      mem_wd   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN_HI;
            n        <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            word_q   <= '0;
          end
        end
        S_LEN_HI: begin
          if (rx_fire) begin
            n     <= {rx_data, n[7:0]};
            state <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (rx_fire) begin
            n <= n_next;
            if (n_next == 16'd0)
              state <= S_DONE;
            else if ({1'b0, n_next} > DEPTH)
              state <= S_ERR;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            word_q   <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= S_WRITE;
              mem_addr <= 32'({word_idx[ADDR_W-1:0], 2'b00});
              mem_wd   <= word_next;
            end
          end
        end
        S_WRITE: begin
          word_idx <= word_idx_inc;
          state    <= (17'(word_idx_inc) == {1'b0, n}) ? S_DONE : S_DATA;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader, using ADDR_W=10 and FIRST_MSB=1.
module tb_instr_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int lat_miss = 0;      // completed words with no mem_we on the following cycle
  int overlap = 0;       // cycles where mem_we and rx_ready are both 1

  logic [7:0]  stream[$];   // data bytes that follow the length
  logic [63:0] exp_q[$];    // {addr, wd} from the reference model
  logic [63:0] obs_q[$];    // {addr, wd} observed on the memory port

  instr_loader #(.ADDR_W(10), .FIRST_MSB(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Write monitor: record each memory write, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      obs_q.push_back({mem_addr, mem_wd});
      if (rx_ready) overlap++;
    end
  end

  // Reference model: word i holds bytes 4i..4i+3 with the first byte as the
  // MSB, at byte address 4i. An oversize image produces no writes.
  function automatic void model_expected(input int n);
    exp_q.delete();
    if (n <= DEPTH)
      for (int i = 0; i < n; i++)
        exp_q.push_back({32'(i * 4), stream[4*i], stream[4*i+1],
                         stream[4*i+2], stream[4*i+3]});
  endfunction

  function automatic void fill_stream(input int nbytes);
    stream.delete();
    for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom_range(0, 255)));
  endfunction

  // Drivers (entered and left at a negedge)
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (rx_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: rx_ready=%b, required 1 within 50 cycles", rx_ready);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_load(input int n, input int max_gap, input bit glitch);
    logic [15:0] len;
    len = 16'(n);
    pulse_start();
    send_byte(len[15:8], $urandom_range(0, max_gap));
    send_byte(len[7:0], $urandom_range(0, max_gap));
    for (int i = 0; i < stream.size(); i++) begin
      if (glitch && i == 1) start = 1'b1;
      send_byte(stream[i], $urandom_range(0, max_gap));
      start = 1'b0;
      if (i % 4 == 3 && mem_we !== 1'b1) lat_miss++;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    int waited;
    waited = 0;
    while (!(done === 1'b1 || err === 1'b1) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!(done === 1'b1 || err === 1'b1)) begin
      checks++; errors++;
      $display("FAIL wait_end_timeout: done=%b err=%b, required one of them 1", done, err);
    end
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #1;
    checks++;
    if ({cpu_hold, rx_ready, mem_we, busy, done, err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: {hold,rdy,we,busy,done,err}=%b required 100000",
               {cpu_hold, rx_ready, mem_we, busy, done, err});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: addr=%h wd=%h required 0/0", mem_addr, mem_wd);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_state: state=%0d required 0 (IDLE)", dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    obs_q.delete(); lat_miss = 0; overlap = 0;
    stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    model_expected(2);
    drive_load(2, 0, 1'b0);
    wait_end();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL normal_count: writes=%0d required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL normal_write%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (lat_miss !== 0) begin
      errors++; $display("FAIL normal_latency: late words=%0d required 0", lat_miss);
    end
    checks++;
    if ({done, cpu_hold, busy, err} !== 4'b1000) begin
      errors++; $display("FAIL normal_end: {done,hold,busy,err}=%b required 1000", {done, cpu_hold, busy, err});
    end
  endtask

  task automatic test_empty();
    obs_q.delete();
    stream.delete();
    drive_load(0, 0, 1'b0);
    checks++;
    if ({done, cpu_hold, busy} !== 3'b100) begin
      errors++; $display("FAIL empty_end: {done,hold,busy}=%b required 100", {done, cpu_hold, busy});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL empty_writes: writes=%0d required 0", obs_q.size());
    end
  endtask

  task automatic test_oversize();
    obs_q.delete();
    stream.delete();
    drive_load(DEPTH + 1, 0, 1'b0);
    checks++;
    if ({err, cpu_hold, rx_ready, done, busy} !== 5'b11000) begin
      errors++; $display("FAIL oversize_end: {err,hold,rdy,done,busy}=%b required 11000",
                         {err, cpu_hold, rx_ready, done, busy});
    end
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || obs_q.size() !== 0) begin
      errors++; $display("FAIL oversize_stay: err=%b writes=%0d required 1/0", err, obs_q.size());
    end
    pulse_start();
    checks++;
    if ({busy, rx_ready, err, cpu_hold} !== 4'b1101) begin
      errors++; $display("FAIL oversize_restart: {busy,rdy,err,hold}=%b required 1101",
                         {busy, rx_ready, err, cpu_hold});
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    rx_valid = 1'b0;
  endtask

  // Boundary: N exactly equal to the depth must complete, not wrap or error.
  task automatic test_full_depth();
    obs_q.delete(); lat_miss = 0; overlap = 0;
    fill_stream(DEPTH * 4);
    model_expected(DEPTH);
    drive_load(DEPTH, 0, 1'b0);
    wait_end();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL full_count: writes=%0d required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_write%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || mem_addr !== 32'h0000_0FFC) begin
      errors++; $display("FAIL full_end: done=%b addr=%h required 1/00000ffc", done, mem_addr);
    end
    checks++;
    if (lat_miss !== 0 || overlap !== 0) begin
      errors++; $display("FAIL full_handshake: late=%0d overlap=%0d required 0/0", lat_miss, overlap);
    end
  endtask

  // rx_valid is held high across WRITE, so rx_ready must drop during WRITE.
  // Later loads use random gaps, and one of them pulses start mid-load.
  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n;
      int gap;
      n   = $urandom_range(1, 8);
      gap = (it < 2) ? 0 : 3;
      obs_q.delete(); lat_miss = 0; overlap = 0;
      fill_stream(n * 4);
      model_expected(n);
      drive_load(n, gap, it == 3);
      wait_end();
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count: writes=%0d required %0d", it, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_write%0d: got %h required %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (lat_miss !== 0 || overlap !== 0 || done !== 1'b1) begin
        errors++; $display("FAIL rand%0d_handshake: late=%0d overlap=%0d done=%b required 0/0/1",
                           it, lat_miss, overlap, done);
      end
    end
  endtask

  // A start pulse in DONE must re-assert cpu_hold on the next cycle.
  task automatic test_start_in_done();
    pulse_start();
    checks++;
    if ({cpu_hold, busy, done} !== 3'b110) begin
      errors++; $display("FAIL done_restart: {hold,busy,done}=%b required 110", {cpu_hold, busy, done});
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    rx_valid = 1'b0;
  endtask

  task automatic test_midload_reset();
    obs_q.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'($urandom_range(0, 255)), 0);
    send_byte(8'($urandom_range(0, 255)), 0);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cpu_hold, rx_ready, mem_we, busy, done, err} !== 6'b100000 ||
        mem_addr !== 32'h0 || mem_wd !== 32'h0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL midreset_outputs: flags=%b addr=%h wd=%h state=%0d required 100000/0/0/0",
               {cpu_hold, rx_ready, mem_we, busy, done, err}, mem_addr, mem_wd, dbg_state);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL midreset_nowrite: writes=%0d required 0", obs_q.size());
    end
    stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    model_expected(1);
    drive_load(1, 0, 1'b0);
    wait_end();
    checks++;
    if (obs_q.size() !== 1) begin
      errors++; $display("FAIL midreset_count: writes=%0d required 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        errors++; $display("FAIL midreset_write: got %h required %h", obs_q[0], exp_q[0]);
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL midreset_done: done=%b required 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_empty();
    test_oversize();
    test_random();
    test_start_in_done();
    test_full_depth();
    test_midload_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
